dff_pipe: RTL and testbench

//  Parametrised multi-stage register pipeline; generalises the single DFF to WIDTH bits x DEPTH stages.

---
 rtl/dff_pipe_pkg.sv | 12 +
 rtl/dff_pipe_if.sv | 23 ++
 rtl/dff_pipe_stage.sv | 38 +++
 rtl/dff_pipe.sv | 70 +++++++
 tb/tb_dff_pipe.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dff_pipe_pkg.sv
// Shared defaults and helpers for the dff_pipe register pipeline.
package dff_pipe_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEPTH = 4;

   // Occupancy counter width: must represent 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/dff_pipe_if.sv
// Producer/consumer handshake bundle for dff_pipe; slave is the pipeline side.
interface dff_pipe_if #(
   parameter int WIDTH = dff_pipe_pkg::DEFAULT_WIDTH,
   parameter int DEPTH = dff_pipe_pkg::DEFAULT_DEPTH
);
   logic                                     in_valid;
   logic                                     in_ready;
   logic [WIDTH-1:0]                         in_data;
   logic                                     out_valid;
   logic                                     out_ready;
   logic [WIDTH-1:0]                         out_data;
   logic [dff_pipe_pkg::cnt_w(DEPTH)-1:0]    count;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, count
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, count
   );
endinterface

// File: rtl/dff_pipe_stage.sv
// One handshaked pipeline stage holding a valid bit and a data word.
module dff_pipe_stage #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             up_valid,
   input  logic [WIDTH-1:0] up_data,
   input  logic             dn_ready,
   output logic             valid,
   output logic [WIDTH-1:0] q
);
   typedef struct packed {
      logic             valid;
      logic [WIDTH-1:0] data;
   } stage_t;

   stage_t st_q;
   logic   load;

   // An empty stage always loads, which is what collapses bubbles.
   assign load = !st_q.valid || dn_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         st_q <= '0;
      end else if (clr) begin
         st_q.valid <= 1'b0;
      end else if (load) begin
         st_q.valid <= up_valid;
         if (up_valid) st_q.data <= up_data;
      end
   end

   assign valid = st_q.valid;
   assign q     = st_q.data;
endmodule

// File: rtl/dff_pipe.sv
// WIDTH x DEPTH valid/ready register pipeline with bubble collapsing and occupancy count.
// Optional flush port enabled by defining DFF_PIPE_FLUSH_EN.
module dff_pipe import dff_pipe_pkg::*; #(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic      clk,
   input  logic      reset,
`ifdef DFF_PIPE_FLUSH_EN
   input  logic      flush,
`endif
   dff_pipe_if.slave bus
);
   localparam int CW = cnt_w(DEPTH);

   logic [DEPTH-1:0] vld;
   logic [WIDTH-1:0] dat [DEPTH];
   logic [DEPTH:0]   rdy;
   logic [CW-1:0]    cnt;
   logic             clr;

`ifdef DFF_PIPE_FLUSH_EN
   assign clr = flush;
`else
   assign clr = 1'b0;
`endif

   // Ready ripples back from the consumer; any empty stage ahead opens the path.
   always_comb begin
      rdy        = '0;
      rdy[DEPTH] = bus.out_ready;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         rdy[i] = !vld[i] || rdy[i+1];
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic             up_v;
      logic [WIDTH-1:0] up_d;
      if (i == 0) begin : g_head
         assign up_v = bus.in_valid;
         assign up_d = bus.in_data;
      end else begin : g_body
         assign up_v = vld[i-1];
         assign up_d = dat[i-1];
      end
      dff_pipe_stage #(.WIDTH(WIDTH)) u_stage (
         .clk      (clk),
         .reset    (reset),
         .clr      (clr),
         .up_valid (up_v),
         .up_data  (up_d),
         .dn_ready (rdy[i+1]),
         .valid    (vld[i]),
         .q        (dat[i])
      );
   end

   always_comb begin
      cnt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         cnt = cnt + CW'(vld[i]);
      end
   end

   assign bus.in_ready  = rdy[0] && !reset && !clr;
   assign bus.out_valid = vld[DEPTH-1];
   assign bus.out_data  = dat[DEPTH-1];
   assign bus.count     = cnt;
endmodule

// File: tb/tb_dff_pipe.sv
// Directed self-checking bench for dff_pipe (WIDTH=8, DEPTH=4).
module tb_dff_pipe;
   logic clk = 1'b0;
   logic reset = 1'b1;
`ifdef DFF_PIPE_FLUSH_EN
   logic flush = 1'b0;
`endif
   int n_run = 0;
   int n_fail = 0;

   dff_pipe_if #(.WIDTH(8), .DEPTH(4)) bus ();

   dff_pipe #(.WIDTH(8), .DEPTH(4)) dut (
      .clk   (clk),
      .reset (reset),
`ifdef DFF_PIPE_FLUSH_EN
      .flush (flush),
`endif
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data = 8'h77;
      bus.out_ready = 1'b1;
      step();
      step();
      n_run++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
      n_run++;
      if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h exp 00", bus.out_data); end
      n_run++;
      if (bus.count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", bus.count); end
      n_run++;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_high got %b exp 0", bus.in_ready); end
      reset = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      n_run++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_after got %b exp 1", bus.in_ready); end
   endtask

   task automatic test_stream();
      bus.out_ready = 1'b1;
      for (int c = 0; c < 14; c++) begin
         if (c < 10) begin
            bus.in_valid = 1'b1;
            bus.in_data = 8'(c + 1);
            #1;
            n_run++;
            if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready c=%0d got %b exp 1", c, bus.in_ready); end
         end else begin
            bus.in_valid = 1'b0;
            bus.in_data = 8'hFF;
         end
         step();
         if (c >= 3 && c <= 12) begin
            n_run++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(c - 2)) begin
               n_fail++;
               $display("FAIL stream_out c=%0d got v=%b d=%h exp v=1 d=%h", c, bus.out_valid, bus.out_data, 8'(c - 2));
            end
         end else begin
            n_run++;
            if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_idle c=%0d got v=%b exp 0", c, bus.out_valid); end
         end
      end
      n_run++;
      if (bus.count !== 3'd0) begin n_fail++; $display("FAIL stream_count_end got %0d exp 0", bus.count); end
   endtask

   task automatic test_stall_fill();
      logic [7:0] exp_d [3];
      exp_d = '{8'hA2, 8'hA3, 8'hA4};
      bus.out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus.in_valid = 1'b1;
         bus.in_data = 8'(8'hA1 + k);
         #1;
         n_run++;
         if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_in_ready k=%0d got %b exp 1", k, bus.in_ready); end
         step();
      end
      bus.in_data = 8'hEE;
      #1;
      n_run++;
      if (bus.count !== 3'd4) begin n_fail++; $display("FAIL fill_count got %0d exp 4", bus.count); end
      n_run++;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full_in_ready got %b exp 0", bus.in_ready); end
      step();
      n_run++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA1) begin
         n_fail++; $display("FAIL fill_hold got v=%b d=%h exp v=1 d=a1", bus.out_valid, bus.out_data);
      end
      n_run++;
      if (bus.count !== 3'd4) begin n_fail++; $display("FAIL fill_hold_count got %0d exp 4", bus.count); end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         n_run++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d[k]) begin
            n_fail++; $display("FAIL drain k=%0d got v=%b d=%h exp v=1 d=%h", k, bus.out_valid, bus.out_data, exp_d[k]);
         end
      end
      step();
      n_run++;
      if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin
         n_fail++; $display("FAIL drain_empty got v=%b cnt=%0d exp v=0 cnt=0", bus.out_valid, bus.count);
      end
   endtask

   task automatic test_bubbles();
      logic       pat_v [4];
      logic [7:0] pat_d [4];
      pat_v = '{1'b1, 1'b0, 1'b1, 1'b0};
      pat_d = '{8'h11, 8'h99, 8'h22, 8'h99};
      bus.out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus.in_valid = pat_v[k];
         bus.in_data = pat_d[k];
         step();
      end
      bus.in_valid = 1'b0;
      step();
      step();
      n_run++;
      if (bus.count !== 3'd2) begin n_fail++; $display("FAIL bubble_count got %0d exp 2", bus.count); end
      n_run++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h11) begin
         n_fail++; $display("FAIL bubble_head got v=%b d=%h exp v=1 d=11", bus.out_valid, bus.out_data);
      end
      bus.out_ready = 1'b1;
      step();
      n_run++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h22) begin
         n_fail++; $display("FAIL bubble_next got v=%b d=%h exp v=1 d=22", bus.out_valid, bus.out_data);
      end
      step();
      n_run++;
      if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin
         n_fail++; $display("FAIL bubble_empty got v=%b cnt=%0d exp v=0 cnt=0", bus.out_valid, bus.count);
      end
   endtask

   task automatic test_full_passthrough();
      logic [7:0] exp_d [4];
      logic [2:0] exp_c [4];
      exp_d = '{8'hB2, 8'hB3, 8'hB4, 8'h55};
      exp_c = '{3'd4, 3'd3, 3'd2, 3'd1};
      bus.out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus.in_valid = 1'b1;
         bus.in_data = 8'(8'hB1 + k);
         step();
      end
      bus.out_ready = 1'b1;
      bus.in_data = 8'h55;
      #1;
      n_run++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL pass_in_ready got %b exp 1", bus.in_ready); end
      for (int k = 0; k < 4; k++) begin
         step();
         bus.in_valid = 1'b0;
         n_run++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d[k] || bus.count !== exp_c[k]) begin
            n_fail++;
            $display("FAIL pass k=%0d got v=%b d=%h cnt=%0d exp v=1 d=%h cnt=%0d",
                     k, bus.out_valid, bus.out_data, bus.count, exp_d[k], exp_c[k]);
         end
      end
      step();
      n_run++;
      if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin
         n_fail++; $display("FAIL pass_empty got v=%b cnt=%0d exp v=0 cnt=0", bus.out_valid, bus.count);
      end
   endtask

   task automatic test_midop_clear();
      bus.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         bus.in_valid = 1'b1;
         bus.in_data = 8'(8'hC1 + k);
         step();
      end
      n_run++;
      if (bus.count !== 3'd3 || bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL clr_pre got cnt=%0d v=%b exp cnt=3 v=0", bus.count, bus.out_valid);
      end
`ifdef DFF_PIPE_FLUSH_EN
      flush = 1'b1;
`else
      reset = 1'b1;
`endif
      bus.in_valid = 1'b1;
      bus.in_data = 8'hDD;
      #1;
      n_run++;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL clr_in_ready got %b exp 0", bus.in_ready); end
      step();
      n_run++;
      if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL clr_post got cnt=%0d v=%b exp cnt=0 v=0", bus.count, bus.out_valid);
      end
`ifdef DFF_PIPE_FLUSH_EN
      flush = 1'b0;
`else
      n_run++;
      if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL clr_out_data got %h exp 00", bus.out_data); end
      reset = 1'b0;
`endif
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      n_run++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL clr_release_in_ready got %b exp 1", bus.in_ready); end
      for (int k = 0; k < 5; k++) begin
         step();
         n_run++;
         if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin
            n_fail++; $display("FAIL clr_stale k=%0d got v=%b cnt=%0d exp v=0 cnt=0", k, bus.out_valid, bus.count);
         end
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data = 8'h00;
      bus.out_ready = 1'b0;
      test_reset();
      test_stream();
      test_stall_fill();
      test_bubbles();
      test_full_passthrough();
      test_midop_clear();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
